// File: rtl/mem_data_responder.sv
// Handshaked byte-addressed data memory for the single-cycle RISC-V core.
// Accepts one load/store at a time, waits WAIT_CYCLES+1 edges, then holds
// the response until the consumer takes it. Little-endian, RV32I sizes.
module mem_data_responder #(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  funct_3,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] read_data,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_BYTES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        write_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [7:0]  mem_q [DEPTH_BYTES];

    logic        accept;
    logic [1:0]  size_m1;
    logic        legal;
    logic        sgn;
    logic        misalign;
    logic [32:0] last_byte;
    logic        req_err;
    logic        access_now;
    logic [AW-1:0] idx;
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] load_val;

    assign req_ready  = (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign read_data  = rdata_q;
    assign rsp_err    = err_q;
    assign accept     = req_valid && (state_q == S_IDLE);
    assign access_now = (state_q == S_WAIT) && (cnt_q == 4'd0);

    // Decode size, legality and sign handling of the captured request
    always_comb begin
        size_m1 = 2'd0;
        legal   = 1'b0;
        sgn     = 1'b0;
        case (f3_q)
            3'b000:  begin size_m1 = 2'd0; legal = 1'b1;     sgn = 1'b1; end
            3'b001:  begin size_m1 = 2'd1; legal = 1'b1;     sgn = 1'b1; end
            3'b010:  begin size_m1 = 2'd3; legal = 1'b1;     sgn = 1'b0; end
            3'b100:  begin size_m1 = 2'd0; legal = !write_q; sgn = 1'b0; end
            3'b101:  begin size_m1 = 2'd1; legal = !write_q; sgn = 1'b0; end
            default: begin size_m1 = 2'd0; legal = 1'b0;     sgn = 1'b0; end
        endcase
    end

    // Range check uses a 33-bit sum so addresses near 2^32 cannot wrap into range
    assign misalign  = (size_m1[0] & addr_q[0]) | (size_m1[1] & addr_q[1]);
    assign last_byte = {1'b0, addr_q} + {31'd0, size_m1};
    assign req_err   = !legal || misalign || (last_byte >= 33'(DEPTH_BYTES));

    // Gather the addressed bytes and extend them to the requested width
    always_comb begin
        idx = addr_q[AW-1:0];
        b0  = mem_q[idx];
        b1  = mem_q[idx + AW'(1)];
        b2  = mem_q[idx + AW'(2)];
        b3  = mem_q[idx + AW'(3)];
        case (size_m1)
            2'd0:    load_val = sgn ? {{24{b0[7]}}, b0} : {24'd0, b0};
            2'd1:    load_val = sgn ? {{16{b1[7]}}, b1, b0} : {16'd0, b1, b0};
            default: load_val = {b3, b2, b1, b0};
        endcase
    end

    // Latch the request fields on accept; they stay put until the next accept
    always_ff @(posedge clk) begin
        if (accept) begin
            write_q <= req_write;
            f3_q    <= funct_3;
            addr_q  <= addr;
            wdata_q <= write_data;
        end
    end

    // Commit a legal store on the edge that enters RESP; reset forces IDLE so an aborted store never lands
    always_ff @(posedge clk) begin
        if (access_now && write_q && !req_err) begin
            for (int k = 0; k < 4; k++) begin
                if (2'(k) <= size_m1) begin
                    mem_q[idx + AW'(k)] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    // Next-state: counter loads WAIT_CYCLES so the response follows accept by WAIT_CYCLES+1 edges
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(WAIT_CYCLES);
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    err_d   = req_err;
                    rdata_d = (req_err || write_q) ? 32'd0 : load_val;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and response registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_data_responder.sv
// Bench for mem_data_responder: directed scenarios followed by random
// traffic, all compared against a byte-array reference model.
module tb_mem_data_responder;

    localparam int DEPTH = 1024;
    localparam int WAITC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  funct_3;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] read_data;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    mem_data_responder #(
        .DEPTH_BYTES(DEPTH),
        .WAIT_CYCLES(WAITC),
        .INIT_FILE("")
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .funct_3(funct_3),
        .addr(addr),
        .write_data(write_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .read_data(read_data),
        .rsp_err(rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: RV32I load/store semantics on a plain byte array
    function automatic void model(input bit w, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output bit er);
        int  size;
        bit  legal;
        bit  sgn;
        longint v;
        size = 1; legal = 0; sgn = 0;
        case (f3)
            3'd0: begin size = 1; legal = 1;  sgn = 1; end
            3'd1: begin size = 2; legal = 1;  sgn = 1; end
            3'd2: begin size = 4; legal = 1;  sgn = 0; end
            3'd4: begin size = 1; legal = !w; sgn = 0; end
            3'd5: begin size = 2; legal = !w; sgn = 0; end
            default: legal = 0;
        endcase
        er = !legal || ((longint'(a) % size) != 0) || (longint'(a) + size - 1 >= DEPTH);
        rd = 32'd0;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < size; i++) v = v + (longint'(ref_mem[int'(a) + i]) << (8 * i));
                if (sgn && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                    v = v - (longint'(1) << (8 * size));
                rd = v[31:0];
            end
        end
    endfunction

    task automatic txn(input string tag, input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
        logic [31:0] m_rd;
        bit          m_er;
        int          lat;
        model(w, f3, a, wd, m_rd, m_er);
        @(negedge clk);
        check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; funct_3 = f3; addr = a; write_data = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; funct_3 = 3'bx; addr = $urandom; write_data = $urandom; req_write = 1'($urandom);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(WAITC + 1));
        rd = read_data;
        er = rsp_err;
        check({tag, ".rdata"}, rd, m_rd);
        check({tag, ".err"}, {31'd0, er}, {31'd0, m_er});
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, ".done"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, hold;
        logic        er;
        logic [31:0] pre0, dummy;
        bit          dummy_er;
        bit          w;
        logic [2:0]  f3;
        logic [31:0] a;

        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; funct_3 = 3'd0;
        addr = 32'd0; write_data = 32'd0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst.read_data", read_data, 32'd0);
        check("rst.rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst.req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < DEPTH / 4; i++) txn("pre", 1'b1, 3'b010, 32'(i * 4), $urandom, rd, er);

        // store then loads back
        txn("sw12", 1'b1, 3'b010, 32'd12, 32'hDEADBEEF, rd, er);
        check("sw12.err", {31'd0, er}, 32'd0);
        txn("lw12", 1'b0, 3'b010, 32'd12, 32'd0, rd, er);
        check("lw12.val", rd, 32'hDEADBEEF);
        txn("lb12", 1'b0, 3'b000, 32'd12, 32'd0, rd, er);
        check("lb12.val", rd, 32'hFFFFFFEF);
        txn("lbu15", 1'b0, 3'b100, 32'd15, 32'd0, rd, er);
        check("lbu15.val", rd, 32'h000000DE);
        txn("lh14", 1'b0, 3'b001, 32'd14, 32'd0, rd, er);
        check("lh14.val", rd, 32'hFFFFDEAD);

        // byte merge
        txn("sb13", 1'b1, 3'b000, 32'd13, 32'h123456AA, rd, er);
        txn("lw12b", 1'b0, 3'b010, 32'd12, 32'd0, rd, er);
        check("merge.val", rd, 32'hDEADAAEF);

        // misalignment
        txn("lw10", 1'b0, 3'b010, 32'd10, 32'd0, rd, er);
        check("lw10.err", {31'd0, er}, 32'd1);
        check("lw10.val", rd, 32'd0);
        txn("sh13", 1'b1, 3'b001, 32'd13, 32'h0000BEEF, rd, er);
        check("sh13.err", {31'd0, er}, 32'd1);
        txn("lw12c", 1'b0, 3'b010, 32'd12, 32'd0, rd, er);
        check("nowrite.val", rd, 32'hDEADAAEF);

        // backpressure with an ignored request pulse
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; funct_3 = 3'b010; addr = 32'd12; write_data = 32'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (WAITC + 1) @(posedge clk);
        #1;
        check("bp.valid0", {31'd0, rsp_valid}, 32'd1);
        hold = read_data;
        check("bp.data0", hold, 32'hDEADAAEF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp.valid", {31'd0, rsp_valid}, 32'd1);
            check("bp.data", read_data, 32'hDEADAAEF);
            check("bp.ready", {31'd0, req_ready}, 32'd0);
            if (i == 1) begin
                req_valid = 1'b1; req_write = 1'b1; funct_3 = 3'b010; addr = 32'd12; write_data = 32'h0;
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp.idle_ready", {31'd0, req_ready}, 32'd1);
        check("bp.idle_valid", {31'd0, rsp_valid}, 32'd0);
        txn("bp.lw12", 1'b0, 3'b010, 32'd12, 32'd0, rd, er);
        check("bp.ignored", rd, 32'hDEADAAEF);

        // range and encoding
        txn("lw1020", 1'b0, 3'b010, 32'd1020, 32'd0, rd, er);
        check("lw1020.err", {31'd0, er}, 32'd0);
        txn("lw1024", 1'b0, 3'b010, 32'd1024, 32'd0, rd, er);
        check("lw1024.err", {31'd0, er}, 32'd1);
        txn("lwtop", 1'b0, 3'b010, 32'hFFFFFFFC, 32'd0, rd, er);
        check("lwtop.err", {31'd0, er}, 32'd1);
        txn("ld011", 1'b0, 3'b011, 32'd16, 32'd0, rd, er);
        check("ld011.err", {31'd0, er}, 32'd1);
        txn("st100", 1'b1, 3'b100, 32'd16, 32'h55, rd, er);
        check("st100.err", {31'd0, er}, 32'd1);

        // reset aborts a store waiting in WAIT
        txn("sw0", 1'b1, 3'b010, 32'd0, 32'hA5A55A5A, rd, er);
        model(1'b0, 3'b010, 32'd0, 32'd0, pre0, dummy_er);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; funct_3 = 3'b010; addr = 32'd0; write_data = 32'h11111111;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort.valid", {31'd0, rsp_valid}, 32'd0);
        check("abort.ready", {31'd0, req_ready}, 32'd1);
        check("abort.rdata", read_data, 32'd0);
        check("abort.err", {31'd0, rsp_err}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort.still_idle", {31'd0, rsp_valid}, 32'd0);
        txn("abort.lw0", 1'b0, 3'b010, 32'd0, 32'd0, rd, er);
        check("abort.lw0val", rd, pre0);
        check("abort.lw0lit", rd, 32'hA5A55A5A);

        // random traffic
        for (int n = 0; n < 300; n++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = 32'($urandom_range(1016, 1030));
                default: a = 32'($urandom_range(0, DEPTH - 1));
            endcase
            if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
            dummy = $urandom;
            txn("rand", w, f3, a, dummy, rd, er);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
